// File: rtl/pipememwb.sv
// ---------------------------------------------------------------------------
// pipememwb : MEM-stage controller and MEM/WB pipeline register.
//
// Takes the EX/MEM register outputs, issues loads/stores to a
// variable-latency data memory over a req/ack handshake, stalls the upstream
// pipeline until the access is acknowledged, and registers results into the
// WB stage. Produces the final register-file write data.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mwreg/mm2reg/mwmem    EX/MEM control (reg write, load, store)
//   malu, mb, mrn         EX/MEM ALU result (address), store data, dest reg
//   mem_is_cond           EX/MEM condition flag
//   dreq/dwe/daddr/dwdata data memory request side
//   drdata/dack           data memory response side
//   mem_stall             upstream hold
//   wwreg/wm2reg/wmo/walu/wrn/wb_is_cond   MEM/WB register outputs
//   wdata                 register-file write data (combinational)
//   mem_err               sticky timeout flag (only with PIPEMEMWB_TIMEOUT_EN)
//
// Optional feature macro: PIPEMEMWB_TIMEOUT_EN adds a 256-cycle access
// timeout with a sticky mem_err output.
// ---------------------------------------------------------------------------
module pipememwb (
  input  logic        clk,
  input  logic        rst,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic        mem_is_cond,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  input  logic [31:0] drdata,
  input  logic        dack,
  output logic        mem_stall,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic        wb_is_cond,
  output logic [31:0] wdata
`ifdef PIPEMEMWB_TIMEOUT_EN
  ,
  output logic        mem_err
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t state_r;
  state_t state_s;

  logic access_s;
  logic tmo_s;
  logic load_s;
  logic take_rdata_s;

`ifdef PIPEMEMWB_TIMEOUT_EN
  logic [7:0] cnt_r;
`endif

  // Handshake decode, next state and WB load enable.
  always_comb begin
    access_s     = mm2reg | mwmem;
    state_s      = state_r;
    tmo_s        = 1'b0;
    dreq         = 1'b0;
`ifdef PIPEMEMWB_TIMEOUT_EN
    if ((state_r == ST_WAIT) && (cnt_r == 8'hFF) && !dack) begin
      tmo_s = 1'b1;
    end else begin
      tmo_s = 1'b0;
    end
`endif
    case (state_r)
      ST_IDLE: begin
        dreq = access_s;
        if (access_s && !dack) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        dreq = 1'b1;
        if (dack || tmo_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        dreq    = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
    mem_stall    = dreq & ~dack & ~tmo_s;
    // WB takes the instruction on every cycle the upstream is not held.
    load_s       = ~mem_stall;
    // A simultaneous load+store is treated as a store, so no read data.
    take_rdata_s = dreq & dack & ~mwmem;
    dwe          = dreq & mwmem;
    daddr        = malu;
    dwdata       = mb;
    wdata        = wm2reg ? wmo : walu;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // MEM/WB pipeline register: instruction on load, bubble while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      wwreg      <= 1'b0;
      wm2reg     <= 1'b0;
      wmo        <= 32'h0000_0000;
      walu       <= 32'h0000_0000;
      wrn        <= 5'd0;
      wb_is_cond <= 1'b0;
    end else if (load_s) begin
      // A timed-out access still retires, but must not write the register file.
      wwreg      <= mwreg & ~tmo_s;
      wm2reg     <= mm2reg & ~tmo_s;
      wmo        <= take_rdata_s ? drdata : 32'h0000_0000;
      walu       <= malu;
      wrn        <= mrn;
      wb_is_cond <= mem_is_cond;
    end else begin
      wwreg      <= 1'b0;
      wm2reg     <= 1'b0;
      wb_is_cond <= 1'b0;
    end
  end

`ifdef PIPEMEMWB_TIMEOUT_EN
  // Wait-cycle counter: zero in IDLE so it is clear on entry to WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= 8'd0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else if (tmo_s) begin
      mem_err <= 1'b1;
    end else begin
      mem_err <= mem_err;
    end
  end
`endif

endmodule
